alu_mul_sequencer: RTL and testbench

- Iterative 32x32 -> 64-bit unsigned shift-add multiplier.
- Owns no adder of its own: it is the initiator side of the ALU port set (src1/src2/ALU_control/bonus_control/rst_n in; result/cout out of the ALU).
- Drives an external 32-bit ALU instance with ADD operations, one iteration per clock, and accumulates the product in its own registers.
- Sits beside the ALU in the datapath as the multi-cycle MUL unit.

---
 rtl/alu_mul_sequencer.sv | 138 +++++++++++++
 tb/tb_alu_mul_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// Iterative unsigned shift-add multiplier that borrows an external ALU for
// its additions. One ADD per clock, 32 iterations, one DONE cycle.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; ALU driven with zeros / NOP
// S_RUN  | one shift-add iteration per clock through the external ALU
// S_DONE | one-cycle done pulse; product/hi_nonzero already registered
module alu_mul_sequencer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DATA_W-1:0]   multiplicand,
  input  logic [DATA_W-1:0]   multiplier,
  output logic                busy,
  output logic                done,
  output logic [2*DATA_W-1:0] product,
  output logic                hi_nonzero,
  output logic                alu_rst_n,
  output logic [DATA_W-1:0]   alu_src1,
  output logic [DATA_W-1:0]   alu_src2,
  output logic [3:0]          alu_control,
  output logic [2:0]          alu_bonus_control,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic                alu_cout
);

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_NOP = 4'b0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] p_hi;
  logic [DATA_W-1:0] p_lo;
  logic [CNT_W-1:0]  count;
  logic              last_iter;
  logic              add_c;
  logic [DATA_W-1:0] add_s;
  logic [DATA_W-1:0] p_hi_nxt;
  logic [DATA_W-1:0] p_lo_nxt;

  assign last_iter = (count == CNT_W'(DATA_W - 1));
  assign alu_rst_n = ~rst;

  // Select the 33-bit partial sum: ALU sum with its real carry-out when the
  // current multiplier bit is set, otherwise the unchanged upper half.
  always_comb begin
    add_c = 1'b0;
    add_s = p_hi;
    if (p_lo[0]) begin
      add_c = alu_cout;
      add_s = alu_result;
    end
  end

  assign p_hi_nxt = {add_c, add_s[DATA_W-1:1]};
  assign p_lo_nxt = {add_s[0], p_lo[DATA_W-1:1]};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode plus status and ALU drive outputs.
  always_comb begin
    state_nxt         = state;
    busy              = 1'b0;
    done              = 1'b0;
    alu_control       = ALU_NOP;
    alu_src1          = '0;
    alu_src2          = '0;
    alu_bonus_control = 3'b000;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy        = 1'b1;
        alu_control = ALU_ADD;
        alu_src1    = p_hi;
        alu_src2    = a_reg;
        if (last_iter) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, shift-add accumulation and result register. The result
  // is loaded on the edge that enters DONE so it is valid alongside done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg      <= '0;
      p_hi       <= '0;
      p_lo       <= '0;
      count      <= '0;
      product    <= '0;
      hi_nonzero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_reg <= multiplicand;
            p_hi  <= '0;
            p_lo  <= multiplier;
            count <= '0;
          end
        end
        S_RUN: begin
          p_hi  <= p_hi_nxt;
          p_lo  <= p_lo_nxt;
          count <= count + CNT_W'(1);
          if (last_iter) begin
            product    <= {p_hi_nxt, p_lo_nxt};
            hi_nonzero <= |p_hi_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer with a behavioural 32-bit ALU (ADD only).
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic        hi_nonzero;
  logic        alu_rst_n;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [3:0]  alu_control;
  logic [2:0]  alu_bonus_control;
  logic [31:0] alu_result;
  logic        alu_cout;
  logic [32:0] alu_sum;

  int n_checks = 0;
  int n_fail   = 0;

  alu_mul_sequencer dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .multiplicand      (multiplicand),
    .multiplier        (multiplier),
    .busy              (busy),
    .done              (done),
    .product           (product),
    .hi_nonzero        (hi_nonzero),
    .alu_rst_n         (alu_rst_n),
    .alu_src1          (alu_src1),
    .alu_src2          (alu_src2),
    .alu_control       (alu_control),
    .alu_bonus_control (alu_bonus_control),
    .alu_result        (alu_result),
    .alu_cout          (alu_cout)
  );

  always #5 clk = ~clk;

  // External ALU: unsigned add with carry-out, zero otherwise.
  always_comb begin
    alu_sum = 33'd0;
    if (alu_rst_n && alu_control == 4'b0010)
      alu_sum = {1'b0, alu_src1} + {1'b0, alu_src2};
    alu_result = alu_sum[31:0];
    alu_cout   = alu_sum[32];
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp_product;
    logic        exp_hi;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Start one multiply from IDLE and wait (bounded) for done.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] prod, output logic hi, output int lat);
    logic drive_ok;
    drive_ok = 1'b1;
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 40) begin
      if (busy && (alu_control != 4'b0010 || alu_bonus_control != 3'b000 ||
                   alu_src2 != a))
        drive_ok = 1'b0;
      multiplicand = $urandom;
      multiplier   = $urandom;
      @(posedge clk);
      #1;
      lat++;
    end
    prod = product;
    hi   = hi_nonzero;
    check("run_alu_drive", {63'd0, drive_ok}, 64'd1);
    check("done_latency_edges", 64'(lat), 64'd32);
    check("busy_with_done", {63'd0, busy}, 64'd1);
    @(posedge clk);
    #1;
    check("done_pulse_width", {63'd0, done}, 64'd0);
    check("idle_after_done", {63'd0, busy}, 64'd0);
  endtask

  vec_t        vecs[10];
  logic [63:0] prod;
  logic        hi;
  int          lat;
  int          done_edge[$];
  logic [63:0] done_prod[$];
  logic [63:0] held_prod;
  logic        held_hi;

  initial begin
    vecs[0] = '{32'd3,         32'd5,         64'h0000_0000_0000_000F, 1'b0};
    vecs[1] = '{32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000, 1'b1};
    vecs[2] = '{32'd0,         32'h1234_5678, 64'd0,                   1'b0};
    vecs[3] = '{32'h1234_5678, 32'd0,         64'd0,                   1'b0};
    vecs[4] = '{32'd7,         32'd6,         64'd42,                  1'b0};
    vecs[5] = '{32'd1,         32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 1'b0};
    vecs[6] = '{32'hFFFF_FFFF, 32'd2,         64'h0000_0001_FFFF_FFFE, 1'b1};
    vecs[7] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b1};
    vecs[8] = '{32'd9,         32'd9,         64'd81,                  1'b0};
    vecs[9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1};

    // Reset state, with start held high while in reset.
    rst          = 1'b1;
    start        = 1'b1;
    multiplicand = 32'd3;
    multiplier   = 32'd5;
    @(posedge clk);
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_product", product, 64'd0);
    check("rst_hi_nonzero", {63'd0, hi_nonzero}, 64'd0);
    check("rst_alu_rst_n", {63'd0, alu_rst_n}, 64'd0);
    check("rst_alu_src", {alu_src1, alu_src2}, 64'd0);
    check("rst_alu_control", {57'd0, alu_bonus_control, alu_control}, 64'd0);
    rst = 1'b0;
    #1;
    check("alu_rst_n_release", {63'd0, alu_rst_n}, 64'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_after_rst_accepted", {63'd0, busy}, 64'd1);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("first_mul_latency", 64'(lat), 64'd32);
    check("first_mul_product", product, 64'd15);
    @(posedge clk);
    #1;

    // Directed vector table.
    foreach (vecs[i]) begin
      run_mul(vecs[i].a, vecs[i].b, prod, hi, lat);
      check($sformatf("vec%0d_product", i), prod, vecs[i].exp_product);
      check($sformatf("vec%0d_hi_nonzero", i), {63'd0, hi}, {63'd0, vecs[i].exp_hi});
    end

    // Hold: result survives operand changes while idle.
    held_prod = product;
    held_hi   = hi_nonzero;
    check("hold_initial_product", held_prod, 64'hFFFF_FFFE_0000_0001);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      multiplicand = $urandom;
      multiplier   = $urandom;
      @(posedge clk);
      #1;
      check("hold_product", product, held_prod);
      check("hold_hi_nonzero", {63'd0, hi_nonzero}, {63'd0, held_hi});
      check("hold_busy", {63'd0, busy}, 64'd0);
      check("hold_alu_src", {alu_src1, alu_src2}, 64'd0);
    end

    // Back-to-back with starts while busy (cycles 10 and 33 ignored, 34 taken).
    @(negedge clk);
    multiplicand = 32'd7;
    multiplier   = 32'd6;
    start        = 1'b1;
    @(posedge clk);
    #1;
    for (int e = 1; e <= 70 && done_edge.size() < 2; e++) begin
      @(negedge clk);
      start = (e == 10 || e == 33 || e == 34);
      if (start) begin
        multiplicand = 32'd9;
        multiplier   = 32'd9;
      end else begin
        multiplicand = $urandom;
        multiplier   = $urandom;
      end
      @(posedge clk);
      #1;
      if (done) begin
        done_edge.push_back(e);
        done_prod.push_back(product);
      end
    end
    start = 1'b0;
    check("b2b_done_count", 64'(done_edge.size()), 64'd2);
    if (done_edge.size() == 2) begin
      check("b2b_first_done_edge", 64'(done_edge[0]), 64'd32);
      check("b2b_first_product", done_prod[0], 64'd42);
      check("b2b_second_done_edge", 64'(done_edge[1]), 64'd66);
      check("b2b_second_product", done_prod[1], 64'd81);
    end
    @(posedge clk);
    #1;

    // Async reset in cycle 15 of a max-operand multiply.
    @(negedge clk);
    multiplicand = 32'hFFFF_FFFF;
    multiplier   = 32'hFFFF_FFFF;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #3;
    check("pre_abort_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_product", product, 64'd0);
    check("abort_alu_rst_n", {63'd0, alu_rst_n}, 64'd0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    begin
      logic saw;
      saw = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(posedge clk);
        #1;
        if (done || busy) saw = 1'b1;
      end
      check("abort_no_done", {63'd0, saw}, 64'd0);
    end
    run_mul(32'd2, 32'd2, prod, hi, lat);
    check("post_abort_product", prod, 64'd4);
    check("post_abort_hi_nonzero", {63'd0, hi}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
